script_stack_seq: RTL and testbench
===================================

Name: script_stack_seq

Overview:
- Hardware replacement for the testbench-side script stack: a parametrised LIFO of WIDTH-bit script items plus a sequencer that drives an AluScript-style handshake.
- Per opcode it pops 0-2 operands, issues them with the opcode, waits for done/error, then pushes 0-2 results.
- Sits between the script fetch/decode front end and AluScript. Adds depth/width generalisation, under/overflow detection, ALU timeout and a host push path.

Parameters:
- WIDTH, 512, bits per stack item and ALU data bus width
- DEPTH, 16, number of stack entries (power of two not required, >= 2)
- OPW, 8, opcode width
- TIMEOUT, 255, maximum cycles to wait for ALU done|error before flagging timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_valid  in  1  host push request (script constant)
- push_data  in  WIDTH  item to push
- exec_valid  in  1  execute request
- exec_opcode  in  OPW  opcode to issue
- exec_nargs  in  2  operands to pop (0,1,2; 3 is illegal)
- ready  out  1  high only in IDLE; push/exec accepted when valid & ready
- resp_valid  out  1  one-cycle pulse when an exec completes
- resp_err  out  3  0 ok, 1 underflow, 2 overflow, 3 alu error, 4 timeout, 5 bad nargs
- count  out  $clog2(DEPTH+1)  current item count
- top_data  out  WIDTH  item at top of stack (0 when empty)
- opcode  out  OPW  to ALU
- put_alu_in1, put_alu_in2  out  1  operand-valid strobes to ALU
- data_alu_in1, data_alu_in2  out  WIDTH  operands (in1 = former top, in2 = former top-1)
- done, error  in  1  ALU completion/failure
- put_alu_out1, put_alu_out2  in  1  result-valid from ALU
- data_alu_out1, data_alu_out2  in  WIDTH  results

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation): state IDLE, count 0, ready 1, resp_valid 0, resp_err 0, put_alu_in* 0, opcode 0, data_alu_in* 0, timeout counter 0. Stack RAM contents are not cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If push_valid and exec_valid are both high, push wins; exec stays pending.
  - Push with count < DEPTH: write at index count; count+1 next cycle; stays IDLE.
  - Push with count == DEPTH: dropped; resp_valid pulse with resp_err=2.
- Exec accepted at cycle N:
  - exec_nargs == 3 -> RESP with err 5.
  - exec_nargs > count -> RESP with err 1; stack untouched.
  - Otherwise pop nargs items (count -= nargs) -> ISSUE.
- ISSUE (cycle N+1): put_alu_in1 high if nargs >= 1, put_alu_in2 high if nargs == 2. Data and opcode are registered and held stable until return to IDLE. Strobes last exactly one cycle. -> WAIT.
- WAIT: timeout counter increments each cycle.
  - On the first clock edge with done|error high:
    - If error: err 3, no pushes. Popped operands are not restored.
    - Else push out1 if put_alu_out1, then out2 if put_alu_out2 (out2 ends on top).
    - If the pushes would exceed DEPTH: nothing is pushed; err 2.
  - Counter reaching TIMEOUT -> err 4; any later done is ignored.
  - Then -> RESP.
- RESP: resp_valid=1 for one cycle with resp_err; -> IDLE (ready high the following cycle).
- Latency, no error: resp_valid at N+2+k, where k = WAIT cycles until done (k >= 1).
- top_data is combinational from the stack RAM at index count-1; it reflects the post-write count the cycle after each update.
- put_alu_out2 without put_alu_out1 pushes out2 only.

Optional Feature:
- SCRIPT_STACK_HWM_EN defined:
  - Extra output hwm [$clog2(DEPTH+1)] holds the maximum count reached since reset; it updates on the same edge as count.
  - Extra input hwm_clr (1) clears hwm to the current count; it has priority over the update in the same cycle.
- Undefined: no hwm/hwm_clr ports and no register.

Test Plan:
- Reset then push 0xDEADBEEF -> count=1, top_data=0xDEADBEEF.
- Exec OP_DUP, nargs=1; ALU returns done with out1=out2=0xDEADBEEF -> count=2, resp_err=0. Repeat -> count=3, all entries 0xDEADBEEF.
- Empty stack, exec nargs=2 -> resp_valid at N+1, resp_err=1, count=0, put_alu_in1 never asserted.
- DEPTH=4, four pushes (count=4); exec nargs=1 returning two results -> resp_err=2, count=3. A 5th push at count=4 -> err 2.
- ALU never responds, TIMEOUT=10 -> resp_err=4 exactly 10 cycles after ISSUE; a late done is ignored; ready returns high.
- Assert rst in WAIT -> next cycle count=0, ready=1, put_alu_in* 0. With SCRIPT_STACK_HWM_EN, hwm=3 after three pushes, and hwm_clr drops it to the current count.

Source files
------------

// File: rtl/script_stack_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : script_stack_seq                                           |
// | Description : LIFO of WIDTH-bit script items with a sequencer that pops  |
// |               0-2 operands, issues them to an ALU, waits for done/error  |
// |               (with timeout) and pushes 0-2 results back. Host constants |
// |               enter through the push path.                               |
// |               Optional macro SCRIPT_STACK_HWM_EN adds a high-water-mark  |
// |               register (hwm output, hwm_clr input).                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module script_stack_seq #(
    parameter int WIDTH   = 512,
    parameter int DEPTH   = 16,
    parameter int OPW     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         exec_valid,
    input  logic [OPW-1:0]               exec_opcode,
    input  logic [1:0]                   exec_nargs,
    output logic                         ready,
    output logic                         resp_valid,
    output logic [2:0]                   resp_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             top_data,
    output logic [OPW-1:0]               opcode,
    output logic                         put_alu_in1,
    output logic                         put_alu_in2,
    output logic [WIDTH-1:0]             data_alu_in1,
    output logic [WIDTH-1:0]             data_alu_in2,
    input  logic                         done,
    input  logic                         error,
    input  logic                         put_alu_out1,
    input  logic                         put_alu_out2,
    input  logic [WIDTH-1:0]             data_alu_out1,
    input  logic [WIDTH-1:0]             data_alu_out2
`ifdef SCRIPT_STACK_HWM_EN
    ,
    input  logic                         hwm_clr,
    output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    localparam logic [2:0] c_ERR_OK    = 3'd0;
    localparam logic [2:0] c_ERR_UNDER = 3'd1;
    localparam logic [2:0] c_ERR_OVER  = 3'd2;
    localparam logic [2:0] c_ERR_ALU   = 3'd3;
    localparam logic [2:0] c_ERR_TMO   = 3'd4;
    localparam logic [2:0] c_ERR_NARGS = 3'd5;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_count;
    logic [c_TW-1:0]  r_tmo;
    logic [OPW-1:0]   r_opcode;
    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic             r_put1;
    logic             r_put2;
    logic             r_resp_valid;
    logic [2:0]       r_resp_err;

    logic [1:0]       w_state_nxt;
    logic [c_CW-1:0]  w_count_nxt;
    logic             w_load;
    logic             w_resp_fire;
    logic [2:0]       w_resp_code;
    logic             w_wr0_en;
    logic [c_AW-1:0]  w_wr0_idx;
    logic [WIDTH-1:0] w_wr0_data;
    logic             w_wr1_en;
    logic [c_AW-1:0]  w_wr1_idx;
    logic [WIDTH-1:0] w_wr1_data;
    logic [c_AW-1:0]  w_top_idx;
    logic [c_AW-1:0]  w_sec_idx;
    logic [c_CW:0]    w_after;

    assign w_top_idx = c_AW'(r_count - c_CW'(1));
    assign w_sec_idx = c_AW'(r_count - c_CW'(2));
    // Count the stack would reach if every ALU result were pushed
    assign w_after   = {1'b0, r_count} + (c_CW+1)'(put_alu_out1) + (c_CW+1)'(put_alu_out2);

    assign ready        = (r_state == c_S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign count        = r_count;
    assign top_data     = (r_count == '0) ? '0 : r_mem[w_top_idx];
    assign opcode       = r_opcode;
    assign put_alu_in1  = r_put1;
    assign put_alu_in2  = r_put2;
    assign data_alu_in1 = r_in1;
    assign data_alu_in2 = r_in2;

    // Next-state, stack pointer and RAM write decisions for the sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        w_resp_fire = 1'b0;
        w_resp_code = c_ERR_OK;
        w_wr0_en    = 1'b0;
        w_wr0_idx   = '0;
        w_wr0_data  = '0;
        w_wr1_en    = 1'b0;
        w_wr1_idx   = '0;
        w_wr1_data  = '0;
        case (r_state)
            c_S_IDLE: begin
                // A push takes the slot; a simultaneous exec simply waits
                if (push_valid) begin
                    if (r_count < c_FULL) begin
                        w_wr0_en    = 1'b1;
                        w_wr0_idx   = c_AW'(r_count);
                        w_wr0_data  = push_data;
                        w_count_nxt = r_count + c_CW'(1);
                    end else begin
                        w_resp_fire = 1'b1;
                        w_resp_code = c_ERR_OVER;
                    end
                end else if (exec_valid) begin
                    if (exec_nargs == 2'd3) begin
                        w_state_nxt = c_S_RESP;
                        w_resp_fire = 1'b1;
                        w_resp_code = c_ERR_NARGS;
                    end else if (c_CW'(exec_nargs) > r_count) begin
                        w_state_nxt = c_S_RESP;
                        w_resp_fire = 1'b1;
                        w_resp_code = c_ERR_UNDER;
                    end else begin
                        w_load      = 1'b1;
                        w_count_nxt = r_count - c_CW'(exec_nargs);
                        w_state_nxt = c_S_ISSUE;
                    end
                end
            end
            c_S_ISSUE: begin
                w_state_nxt = c_S_WAIT;
            end
            c_S_WAIT: begin
                if (error) begin
                    w_state_nxt = c_S_RESP;
                    w_resp_fire = 1'b1;
                    w_resp_code = c_ERR_ALU;
                end else if (done) begin
                    w_state_nxt = c_S_RESP;
                    w_resp_fire = 1'b1;
                    if (w_after > {1'b0, c_FULL}) begin
                        w_resp_code = c_ERR_OVER;
                    end else begin
                        // out1 goes in first so that out2 ends on top
                        w_wr0_en    = put_alu_out1;
                        w_wr0_idx   = c_AW'(r_count);
                        w_wr0_data  = data_alu_out1;
                        w_wr1_en    = put_alu_out2;
                        w_wr1_idx   = c_AW'(r_count + c_CW'(put_alu_out1));
                        w_wr1_data  = data_alu_out2;
                        w_count_nxt = w_after[c_CW-1:0];
                    end
                end else if (r_tmo >= c_TMO_LAST) begin
                    w_state_nxt = c_S_RESP;
                    w_resp_fire = 1'b1;
                    w_resp_code = c_ERR_TMO;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Sequencer state, pointer, ALU-facing and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_count      <= '0;
            r_tmo        <= '0;
            r_opcode     <= '0;
            r_in1        <= '0;
            r_in2        <= '0;
            r_put1       <= 1'b0;
            r_put2       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= c_ERR_OK;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_resp_valid <= w_resp_fire;
            if (w_resp_fire) begin
                r_resp_err <= w_resp_code;
            end
            // Operands are captured at pop time and held until the next exec
            if (w_load) begin
                r_opcode <= exec_opcode;
                r_in1    <= (exec_nargs != 2'd0) ? r_mem[w_top_idx] : '0;
                r_in2    <= (exec_nargs == 2'd2) ? r_mem[w_sec_idx] : '0;
            end
            r_put1 <= w_load && (exec_nargs != 2'd0);
            r_put2 <= w_load && (exec_nargs == 2'd2);
            // The ISSUE cycle already counts towards the ALU time budget
            case (r_state)
                c_S_ISSUE: r_tmo <= c_TW'(1);
                c_S_WAIT:  r_tmo <= r_tmo + c_TW'(1);
                default:   r_tmo <= '0;
            endcase
        end
    end

    // Stack storage; contents survive reset but no write lands while in reset
    always_ff @(posedge clk) begin
        if (!rst && w_wr0_en) begin
            r_mem[w_wr0_idx] <= w_wr0_data;
        end
        if (!rst && w_wr1_en) begin
            r_mem[w_wr1_idx] <= w_wr1_data;
        end
    end

`ifdef SCRIPT_STACK_HWM_EN
    logic [c_CW-1:0] r_hwm;

    // Highest occupancy since reset or the last clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwm <= '0;
        end else if (hwm_clr) begin
            r_hwm <= r_count;
        end else if (w_count_nxt > r_hwm) begin
            r_hwm <= w_count_nxt;
        end
    end

    assign hwm = r_hwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_script_stack_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_script_stack_seq                                        |
// | Description : Self-checking bench for script_stack_seq using a queue     |
// |               reference stack and a behavioural ALU responder.           |
// |               Honours SCRIPT_STACK_HWM_EN when defined.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_script_stack_seq;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int TMO = 10;

    logic          clk;
    logic          rst;
    logic          push_valid;
    logic [W-1:0]  push_data;
    logic          exec_valid;
    logic [7:0]    exec_opcode;
    logic [1:0]    exec_nargs;
    logic          ready;
    logic          resp_valid;
    logic [2:0]    resp_err;
    logic [2:0]    count;
    logic [W-1:0]  top_data;
    logic [7:0]    opcode;
    logic          put_alu_in1;
    logic          put_alu_in2;
    logic [W-1:0]  data_alu_in1;
    logic [W-1:0]  data_alu_in2;
    logic          done;
    logic          error;
    logic          put_alu_out1;
    logic          put_alu_out2;
    logic [W-1:0]  data_alu_out1;
    logic [W-1:0]  data_alu_out2;
`ifdef SCRIPT_STACK_HWM_EN
    logic          hwm_clr;
    logic [2:0]    hwm;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] model[$];
    int m_hwm = 0;

    script_stack_seq #(.WIDTH(W), .DEPTH(D), .OPW(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_data(push_data),
        .exec_valid(exec_valid), .exec_opcode(exec_opcode), .exec_nargs(exec_nargs),
        .ready(ready), .resp_valid(resp_valid), .resp_err(resp_err),
        .count(count), .top_data(top_data), .opcode(opcode),
        .put_alu_in1(put_alu_in1), .put_alu_in2(put_alu_in2),
        .data_alu_in1(data_alu_in1), .data_alu_in2(data_alu_in2),
        .done(done), .error(error),
        .put_alu_out1(put_alu_out1), .put_alu_out2(put_alu_out2),
        .data_alu_out1(data_alu_out1), .data_alu_out2(data_alu_out2)
`ifdef SCRIPT_STACK_HWM_EN
        , .hwm_clr(hwm_clr), .hwm(hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] top_exp();
        if (model.size() == 0) return '0;
        return model[model.size()-1];
    endfunction

    function automatic void upd_hwm();
        if (model.size() > m_hwm) m_hwm = model.size();
    endfunction

    task automatic clear_alu();
        done = 1'b0; error = 1'b0; put_alu_out1 = 1'b0; put_alu_out2 = 1'b0;
        data_alu_out1 = '0; data_alu_out2 = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        push_valid = 1'b0; push_data = '0;
        exec_valid = 1'b0; exec_opcode = '0; exec_nargs = '0;
        clear_alu();
        step();
        step();
        rst = 1'b0;
        model.delete();
        m_hwm = 0;
        check("rst_count", count, 0);
        check("rst_ready", ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_puts", {put_alu_in1, put_alu_in2}, 0);
        check("rst_opcode", opcode, 0);
        check("rst_data_in", {data_alu_in1, data_alu_in2}, 0);
        check("rst_top", top_data, 0);
`ifdef SCRIPT_STACK_HWM_EN
        check("rst_hwm", hwm, 0);
`endif
    endtask

    task automatic do_push(input logic [W-1:0] d);
        int n0;
        n0 = model.size();
        push_valid = 1'b1;
        push_data  = d;
        step();
        push_valid = 1'b0;
        if (n0 < D) begin
            model.push_back(d);
            check("push_resp_v", resp_valid, 0);
        end else begin
            check("push_ovf_resp_v", resp_valid, 1);
            check("push_ovf_err", resp_err, 2);
        end
        check("push_count", count, model.size());
        check("push_top", top_data, top_exp());
        upd_hwm();
    endtask

    // lat: WAIT cycle in which the ALU answers (0 = never); late: pulse done after resp
    task automatic do_exec(input logic [7:0] op, input logic [1:0] na, input int lat,
                           input bit aerr, input bit p1, input bit p2,
                           input logic [W-1:0] d1, input logic [W-1:0] d2, input bit late);
        logic [W-1:0] e_in1;
        logic [W-1:0] e_in2;
        int resp_t;
        int exp_err;
        bit early;
        check("exec_ready_pre", ready, 1);
        exec_valid  = 1'b1;
        exec_opcode = op;
        exec_nargs  = na;
        step();
        exec_valid = 1'b0;
        if (na == 2'd3 || int'(na) > model.size()) begin
            exp_err = (na == 2'd3) ? 5 : 1;
            check("fast_resp_v", resp_valid, 1);
            check("fast_resp_err", resp_err, exp_err);
            check("fast_no_put", {put_alu_in1, put_alu_in2}, 0);
            check("fast_count", count, model.size());
        end else begin
            e_in1 = '0;
            e_in2 = '0;
            if (na >= 2'd1) e_in1 = model.pop_back();
            if (na == 2'd2) e_in2 = model.pop_back();
            check("issue_put1", put_alu_in1, na >= 2'd1);
            check("issue_put2", put_alu_in2, na == 2'd2);
            check("issue_opcode", opcode, op);
            if (na >= 2'd1) check("issue_data1", data_alu_in1, e_in1);
            if (na == 2'd2) check("issue_data2", data_alu_in2, e_in2);
            check("issue_count", count, model.size());
            check("issue_resp_v", resp_valid, 0);
            // Response lands lat+1 cycles after ISSUE, or TMO cycles after it if the ALU is slower
            if (lat >= 1 && lat + 1 <= TMO) begin
                resp_t = lat + 1;
                if (aerr) begin
                    exp_err = 3;
                end else if (model.size() + int'(p1) + int'(p2) > D) begin
                    exp_err = 2;
                end else begin
                    exp_err = 0;
                    if (p1) model.push_back(d1);
                    if (p2) model.push_back(d2);
                end
            end else begin
                resp_t  = TMO;
                exp_err = 4;
            end
            early = 1'b0;
            for (int t = 0; t < resp_t; t++) begin
                if (lat >= 1 && t == lat) begin
                    done = !aerr; error = aerr;
                    put_alu_out1 = p1; put_alu_out2 = p2;
                    data_alu_out1 = d1; data_alu_out2 = d2;
                end
                step();
                clear_alu();
                if (t + 1 < resp_t && (resp_valid || put_alu_in1 || put_alu_in2 || ready))
                    early = 1'b1;
            end
            check("wait_quiet", early, 0);
            check("resp_v", resp_valid, 1);
            check("resp_err", resp_err, exp_err);
            check("resp_count", count, model.size());
            check("resp_top", top_data, top_exp());
            if (na >= 2'd1) check("resp_data1_held", data_alu_in1, e_in1);
            if (late) begin
                done = 1'b1; put_alu_out1 = 1'b1; data_alu_out1 = 32'h0BAD0BAD;
            end
        end
        step();
        clear_alu();
        upd_hwm();
        check("post_ready", ready, 1);
        check("post_resp_v", resp_valid, 0);
        check("post_count", count, model.size());
        check("post_top", top_data, top_exp());
    endtask

    initial begin
`ifdef SCRIPT_STACK_HWM_EN
        hwm_clr = 1'b0;
`endif
        apply_reset();

        // Constant then two DUPs
        do_push(32'hDEADBEEF);
        do_exec(8'h01, 2'd1, 2, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        do_exec(8'h01, 2'd1, 1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        check("dup_count", count, 3);
`ifdef SCRIPT_STACK_HWM_EN
        check("dup_hwm", hwm, m_hwm);
`endif

        // Fill, overflow push, overflowing results
        do_push(32'h11111111);
        do_push(32'h22222222);
        do_exec(8'h02, 2'd1, 1, 1'b0, 1'b1, 1'b1, 32'h33333333, 32'h44444444, 1'b0);
        check("ovf_res_count", count, 3);

        // Illegal nargs
        do_exec(8'h03, 2'd3, 1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Push and exec together: push wins, exec is taken afterwards
        push_valid = 1'b1; push_data = 32'h55555555;
        exec_valid = 1'b1; exec_opcode = 8'h04; exec_nargs = 2'd2;
        step();
        push_valid = 1'b0;
        model.push_back(32'h55555555);
        upd_hwm();
        check("both_count", count, model.size());
        check("both_ready", ready, 1);
        check("both_no_put", put_alu_in1, 0);
        // out2 alone is pushed
        do_exec(8'h04, 2'd2, 3, 1'b0, 1'b0, 1'b1, 32'h66666666, 32'h77777777, 1'b0);

        // Silent ALU: timeout, then a late done that must be ignored
        do_exec(8'h05, 2'd1, 0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Drain, then underflow on empty
        do_exec(8'h06, 2'd2, 1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        while (model.size() > 0)
            do_exec(8'h06, 2'd1, 1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        do_exec(8'h07, 2'd2, 1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // ALU error: operands consumed, nothing pushed
        do_push(32'h0000AAAA);
        do_push(32'h0000BBBB);
        do_exec(8'h08, 2'd2, 4, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 1'b0);
        // Zero-operand op producing two results
        do_exec(8'h09, 2'd0, 2, 1'b0, 1'b1, 1'b1, 32'hCAFE0001, 32'hCAFE0002, 1'b0);

        // Random mix against the reference stack
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_push($urandom);
            end else begin
                do_exec(8'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                        ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                        $urandom, $urandom, 1'b0);
            end
        end

        // Reset while waiting on the ALU
        apply_reset();
        do_push(32'hA5A5A5A5);
        exec_valid = 1'b1; exec_opcode = 8'h33; exec_nargs = 2'd1;
        step();
        exec_valid = 1'b0;
        check("rstw_issue_put1", put_alu_in1, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model.delete();
        m_hwm = 0;
        check("rstw_count", count, 0);
        check("rstw_ready", ready, 1);
        check("rstw_puts", {put_alu_in1, put_alu_in2}, 0);
        check("rstw_resp_v", resp_valid, 0);
        check("rstw_opcode", opcode, 0);

`ifdef SCRIPT_STACK_HWM_EN
        do_push(32'h1);
        do_push(32'h2);
        do_push(32'h3);
        check("hwm_three", hwm, 3);
        do_exec(8'h0A, 2'd2, 1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("hwm_hold", hwm, 3);
        hwm_clr = 1'b1;
        step();
        hwm_clr = 1'b0;
        m_hwm = model.size();
        check("hwm_clr", hwm, m_hwm);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
